// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: RV32 opcodes that write rd and the
// decode of register-write intent for retired instructions.
package wb_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam int RD_W = 5;

    // Packed width of one buffered entry {we, rd, data} for a given data width.
    function automatic int wb_entry_width(input int bitsize);
        return 1 + RD_W + bitsize;
    endfunction

    // Writes to x0 are architecturally discarded, so they carry no write intent.
    function automatic logic wb_decode_we(input logic [31:0] instr);
        logic writes_rd;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP, OPC_LOAD: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
        return writes_rd && (instr[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Power-of-two circular buffer holding writeback entries; head is always
// presented combinationally from storage, occupancy drives full/empty.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("wb_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/wb_stage_buffered.sv
// Buffered writeback stage: queues retired instructions from MEM, drains the
// head to the register file under ack, forwards the head and counts retires.
module wb_stage_buffered
    import wb_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               MEM_WB_give_i,
    output logic               WB_MEM_get_o,
    input  logic [31:0]        MEM_WB_instruction_i,
    input  logic [BITSIZE-1:0] MEM_WB_data_i,
    output logic [4:0]         WB_REG_rd_o,
    output logic [BITSIZE-1:0] WB_REG_d_o,
    output logic               WB_REG_access_o,
    input  logic               REG_WB_ack_i,
    output logic               WB_FWD_valid_o,
    output logic [4:0]         WB_FWD_rd_o,
    output logic [BITSIZE-1:0] WB_FWD_d_o,
    output logic               WB_empty_o,
    output logic [CNT_W-1:0]   WB_retired_o
);

    // The entry layout depends on BITSIZE, so the struct is declared here.
    typedef struct packed {
        logic               we;
        logic [RD_W-1:0]    rd;
        logic [BITSIZE-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = wb_entry_width(BITSIZE);
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HEAD = 1'b1
    } head_state_e;

    head_state_e      state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    wb_entry_t        enq_entry;
    wb_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic             push;
    logic             retire;
    logic             head_valid;
    logic             head_write;
    logic             enq_we;

    always_comb begin
        enq_we         = wb_decode_we(MEM_WB_instruction_i);
        enq_entry.we   = enq_we;
        enq_entry.rd   = enq_we ? MEM_WB_instruction_i[11:7] : 5'd0;
        enq_entry.data = MEM_WB_data_i;
    end

    // get depends only on registered occupancy: no bypass when full.
    assign WB_MEM_get_o = !fifo_full;
    assign push         = MEM_WB_give_i && !fifo_full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn_i),
        .push_i  (push),
        .pop_i   (retire),
        .wdata_i (enq_entry),
        .head_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_entry = head_bits;

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next state tracks the occupancy that results from this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (push) state_d = S_HEAD;
            S_HEAD: if (retire && !push && fifo_count == OCC_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_valid      = (state_q == S_HEAD);
        head_write      = head_valid && head_entry.we;
        retire          = head_valid && (!head_entry.we || REG_WB_ack_i);
        WB_REG_access_o = !head_write;
        WB_REG_rd_o     = head_write ? head_entry.rd   : 5'd0;
        WB_REG_d_o      = head_write ? head_entry.data : '0;
        WB_FWD_valid_o  = head_write;
        WB_FWD_rd_o     = head_write ? head_entry.rd   : 5'd0;
        WB_FWD_d_o      = head_write ? head_entry.data : '0;
        WB_empty_o      = fifo_empty;
    end

    always_comb begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    assign WB_retired_o = retired_q;

endmodule

// File: tb/tb_wb_stage_buffered.sv
// Bench for wb_stage_buffered: directed vector table, asynchronous reset and
// counter-wrap sequences, then random traffic against a queue-based model.
module tb_wb_stage_buffered;

    localparam int BITSIZE = 32;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;

    localparam logic [31:0] ADDI5 = 32'h00000293;
    localparam logic [31:0] ADDI0 = 32'h00000013;
    localparam logic [31:0] SW0   = 32'h00002023;
    localparam logic [31:0] BEQ0  = 32'h00000063;
    localparam logic [31:0] LUI1  = 32'h000010B7;
    localparam logic [31:0] LUI2  = 32'h00002137;
    localparam logic [31:0] LUI3  = 32'h000031B7;
    localparam logic [31:0] LUI4  = 32'h00004237;

    logic               clk = 1'b0;
    logic               resetn_i;
    logic               MEM_WB_give_i;
    logic               WB_MEM_get_o;
    logic [31:0]        MEM_WB_instruction_i;
    logic [BITSIZE-1:0] MEM_WB_data_i;
    logic [4:0]         WB_REG_rd_o;
    logic [BITSIZE-1:0] WB_REG_d_o;
    logic               WB_REG_access_o;
    logic               REG_WB_ack_i;
    logic               WB_FWD_valid_o;
    logic [4:0]         WB_FWD_rd_o;
    logic [BITSIZE-1:0] WB_FWD_d_o;
    logic               WB_empty_o;
    logic [CNT_W-1:0]   WB_retired_o;

    always #5 clk = ~clk;

    wb_stage_buffered #(
        .BITSIZE (BITSIZE),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk                  (clk),
        .resetn_i             (resetn_i),
        .MEM_WB_give_i        (MEM_WB_give_i),
        .WB_MEM_get_o         (WB_MEM_get_o),
        .MEM_WB_instruction_i (MEM_WB_instruction_i),
        .MEM_WB_data_i        (MEM_WB_data_i),
        .WB_REG_rd_o          (WB_REG_rd_o),
        .WB_REG_d_o           (WB_REG_d_o),
        .WB_REG_access_o      (WB_REG_access_o),
        .REG_WB_ack_i         (REG_WB_ack_i),
        .WB_FWD_valid_o       (WB_FWD_valid_o),
        .WB_FWD_rd_o          (WB_FWD_rd_o),
        .WB_FWD_d_o           (WB_FWD_d_o),
        .WB_empty_o           (WB_empty_o),
        .WB_retired_o         (WB_retired_o)
    );

    typedef struct {
        logic        give;
        logic [31:0] instr;
        logic [31:0] data;
        logic        ack;
        logic        get;
        logic        access;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        fwd;
        logic        empty;
        logic [3:0]  retired;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } mentry_t;

    vec_t    vecs[$];
    mentry_t mq[$];
    int      mretired;
    int      total = 0;
    int      bad   = 0;

    function automatic vec_t mkVec(input logic give, input logic [31:0] instr,
                                   input logic [31:0] data, input logic ack,
                                   input logic get, input logic access,
                                   input logic [4:0] rd, input logic [31:0] d,
                                   input logic fwd, input logic empty,
                                   input logic [3:0] retired);
        vec_t v;
        v.give = give; v.instr = instr; v.data = data; v.ack = ack;
        v.get = get; v.access = access; v.rd = rd; v.d = d;
        v.fwd = fwd; v.empty = empty; v.retired = retired;
        return v;
    endfunction

    // Register-writing opcodes per the RV32I base set, x0 excluded.
    function automatic logic modelWe(input logic [31:0] instr);
        logic [6:0] opc;
        opc = instr[6:0];
        if (instr[11:7] == 5'd0) return 1'b0;
        return (opc == 7'h37) || (opc == 7'h17) || (opc == 7'h6F) || (opc == 7'h67) ||
               (opc == 7'h13) || (opc == 7'h33) || (opc == 7'h03);
    endfunction

    task automatic modelReset();
        mq.delete();
        mretired = 0;
    endtask

    // One rising edge of the reference: retire decision and accept decision
    // both use the occupancy seen before the edge.
    task automatic modelEdge();
        bit      canTake;
        bit      doRetire;
        mentry_t e;
        canTake  = (mq.size() < DEPTH);
        doRetire = (mq.size() > 0) && (!mq[0].we || REG_WB_ack_i);
        if (doRetire) begin
            void'(mq.pop_front());
            mretired = (mretired + 1) % (1 << CNT_W);
        end
        if (MEM_WB_give_i && canTake) begin
            e.we   = modelWe(MEM_WB_instruction_i);
            e.rd   = e.we ? MEM_WB_instruction_i[11:7] : 5'd0;
            e.data = MEM_WB_data_i;
            mq.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic get, input logic access,
                               input logic [4:0] rd, input logic [31:0] d,
                               input logic fwd, input logic empty, input logic [3:0] retired);
        check({tag, ".get"},       32'(WB_MEM_get_o),    32'(get));
        check({tag, ".access"},    32'(WB_REG_access_o), 32'(access));
        check({tag, ".reg_rd"},    32'(WB_REG_rd_o),     32'(rd));
        check({tag, ".reg_d"},     WB_REG_d_o,           d);
        check({tag, ".fwd_valid"}, 32'(WB_FWD_valid_o),  32'(fwd));
        check({tag, ".fwd_rd"},    32'(WB_FWD_rd_o),     32'(rd));
        check({tag, ".fwd_d"},     WB_FWD_d_o,           d);
        check({tag, ".empty"},     32'(WB_empty_o),      32'(empty));
        check({tag, ".retired"},   32'(WB_retired_o),    32'(retired));
    endtask

    task automatic checkVsModel(input string tag);
        logic wr;
        wr = (mq.size() > 0) && mq[0].we;
        checkOutput(tag, mq.size() < DEPTH, !wr,
                    wr ? mq[0].rd : 5'd0, wr ? mq[0].data : 32'd0,
                    wr, mq.size() == 0, 4'(mretired));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge.
    task automatic applyStimulus(input logic give, input logic [31:0] instr,
                                 input logic [31:0] data, input logic ack);
        MEM_WB_give_i        = give;
        MEM_WB_instruction_i = instr;
        MEM_WB_data_i        = data;
        REG_WB_ack_i         = ack;
        @(negedge clk);
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        logic [31:0] opcList [11];
        logic [31:0] r;
        logic [4:0]  rdr;

        resetn_i             = 1'b0;
        MEM_WB_give_i        = 1'b0;
        MEM_WB_instruction_i = '0;
        MEM_WB_data_i        = '0;
        REG_WB_ack_i         = 1'b0;
        modelReset();

        @(negedge clk);
        checkOutput("reset", 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1, 4'd0);
        @(posedge clk);
        #1 resetn_i = 1'b1;

        // Directed table: expectations are the outputs seen before the edge
        // that consumes each row's inputs.
        vecs.push_back(mkVec(1, ADDI5, 32'h1234, 1,  1, 1, 0, 32'h0,    0, 1, 0));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    1,  1, 0, 5, 32'h1234, 1, 0, 0));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    0,  1, 1, 0, 32'h0,    0, 1, 1));
        vecs.push_back(mkVec(1, ADDI0, 32'h11,   0,  1, 1, 0, 32'h0,    0, 1, 1));
        vecs.push_back(mkVec(1, SW0,   32'h22,   0,  1, 1, 0, 32'h0,    0, 0, 1));
        vecs.push_back(mkVec(1, BEQ0,  32'h33,   0,  1, 1, 0, 32'h0,    0, 0, 2));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    0,  1, 1, 0, 32'h0,    0, 0, 3));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    0,  1, 1, 0, 32'h0,    0, 1, 4));
        vecs.push_back(mkVec(1, LUI1,  32'h101,  0,  1, 1, 0, 32'h0,    0, 1, 4));
        vecs.push_back(mkVec(1, LUI2,  32'h102,  0,  1, 0, 1, 32'h101,  1, 0, 4));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mkVec(1, LUI3, 32'h103, 0,  0, 0, 1, 32'h101, 1, 0, 4));
        end
        vecs.push_back(mkVec(1, LUI3,  32'h103,  1,  0, 0, 1, 32'h101,  1, 0, 4));
        vecs.push_back(mkVec(1, LUI3,  32'h103,  1,  1, 0, 2, 32'h102,  1, 0, 5));
        vecs.push_back(mkVec(1, LUI4,  32'h104,  1,  1, 0, 3, 32'h103,  1, 0, 6));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    1,  1, 0, 4, 32'h104,  1, 0, 7));
        vecs.push_back(mkVec(0, 32'h0, 32'h0,    0,  1, 1, 0, 32'h0,    0, 1, 8));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].give, vecs[i].instr, vecs[i].data, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].get, vecs[i].access, vecs[i].rd,
                        vecs[i].d, vecs[i].fwd, vecs[i].empty, vecs[i].retired);
            finishCycle();
        end

        // Asynchronous reset with two entries queued, observed before the next edge.
        applyStimulus(1, LUI1, 32'h201, 0);
        finishCycle();
        applyStimulus(1, LUI2, 32'h202, 0);
        finishCycle();
        MEM_WB_give_i = 1'b0;
        resetn_i      = 1'b0;
        #2;
        checkOutput("async_reset", 1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b1, 4'd0);
        modelReset();
        @(posedge clk);
        #1 resetn_i = 1'b1;

        // Seventeen no-write retires wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, ADDI0, $urandom, 1'($urandom_range(0, 1)));
            checkVsModel($sformatf("wrap%0d", i));
            finishCycle();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 32'h0, 32'h0, 0);
            checkVsModel($sformatf("wrapdrain%0d", i));
            finishCycle();
        end
        check("wrap_count", 32'(WB_retired_o), 32'd1);

        opcList = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h13, 32'h33, 32'h03,
                    32'h23, 32'h63, 32'h73, 32'h0B};
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            rdr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus($urandom_range(0, 3) != 0,
                          {r[31:12], rdr, opcList[$urandom_range(0, 10)][6:0]},
                          $urandom, $urandom_range(0, 2) != 0);
            checkVsModel($sformatf("rand%0d", i));
            finishCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
